// File: rtl/clock_pkg.sv
// Shared types, reset constants and BCD helpers for the wall-clock alarm stage.
// Times are 12-hour BCD: hour 01..12, minute 00..59, plus a PM flag.
package clock_pkg;

  typedef logic [7:0] bcd8_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_e;

  localparam bcd8_t RESET_HH = 8'h12;
  localparam bcd8_t RESET_MM = 8'h00;

  // Both nibbles are checked, so 0x0A or 0x5F are rejected as well.
  function automatic logic bcd_time_legal(input bcd8_t hh, input bcd8_t mm);
    logic hh_ok;
    logic mm_ok;
    hh_ok = ((hh[7:4] == 4'd0) && (hh[3:0] >= 4'd1) && (hh[3:0] <= 4'd9)) ||
            ((hh[7:4] == 4'd1) && (hh[3:0] <= 4'd2));
    mm_ok = (mm[7:4] <= 4'd5) && (mm[3:0] <= 4'd9);
    return hh_ok && mm_ok;
  endfunction

  function automatic logic [6:0] bcd_to_bin(input bcd8_t v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  // Valid for 0..99.
  function automatic bcd8_t bin_to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (v >= 7'(i * 10)) tens = 4'(i);
    end
    return {tens, 4'(v - 7'(tens) * 7'd10)};
  endfunction

endpackage

// File: rtl/alarm_unit_if.sv
// Bundle between the wall clock / user controls and the alarm stage.
// set_valid, stop and snooze are single-cycle strobes with no ready: the alarm
// accepts every strobe in the cycle it is high, so the sender never waits.
interface alarm_unit_if;
  import clock_pkg::*;

  logic         ena;
  bcd8_t        hh;
  bcd8_t        mm;
  bcd8_t        ss;
  logic         pm;
  logic         arm_en;
  logic         set_valid;
  bcd8_t        set_hh;
  bcd8_t        set_mm;
  logic         set_pm;
  logic         stop;
  logic         snooze;

  logic         ring;
  logic         snoozing;
  logic         set_err;
  bcd8_t        alm_hh;
  bcd8_t        alm_mm;
  logic         alm_pm;
  alarm_state_e dbg_state;

  modport master (
    output ena, hh, mm, ss, pm, arm_en, set_valid, set_hh, set_mm, set_pm, stop, snooze,
    input  ring, snoozing, set_err, alm_hh, alm_mm, alm_pm, dbg_state
  );

  modport slave (
    input  ena, hh, mm, ss, pm, arm_en, set_valid, set_hh, set_mm, set_pm, stop, snooze,
    output ring, snoozing, set_err, alm_hh, alm_mm, alm_pm, dbg_state
  );

endinterface

// File: rtl/bcd_time_add.sv
// Combinational 12-hour BCD add of a fixed number of minutes, with hour
// carry (12 -> 01 keeps PM, 11 -> 12 toggles PM).
module bcd_time_add
  import clock_pkg::*;
#(
  parameter int unsigned ADD_MIN = 5
) (
  input  bcd8_t hh_i,
  input  bcd8_t mm_i,
  input  logic  pm_i,
  output bcd8_t hh_o,
  output bcd8_t mm_o,
  output logic  pm_o
);

  logic [6:0] mm_raw;
  logic [6:0] mm_wrap;
  logic       carry;
  logic [6:0] hh_bin;
  logic [6:0] hh_inc;

  always_comb begin
    mm_raw  = bcd_to_bin(mm_i) + 7'(ADD_MIN);
    carry   = (mm_raw >= 7'd60);
    mm_wrap = carry ? (mm_raw - 7'd60) : mm_raw;
    hh_bin  = bcd_to_bin(hh_i);
    hh_inc  = hh_bin;
    pm_o    = pm_i;
    if (carry) begin
      if (hh_bin == 7'd12) begin
        hh_inc = 7'd1;
      end else begin
        hh_inc = hh_bin + 7'd1;
        if (hh_inc == 7'd12) pm_o = ~pm_i;
      end
    end
    hh_o = bin_to_bcd(hh_inc);
    mm_o = bin_to_bcd(mm_wrap);
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage behind the 12-hour BCD wall clock: stored alarm time, ring with
// automatic timeout, stop, and a single fixed-length snooze.
module alarm_unit
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input logic         clk,
  input logic         reset_n,
  alarm_unit_if.slave bus
);

  alarm_state_e state_q, state_d;
  bcd8_t        alm_hh_q, alm_hh_d;
  bcd8_t        alm_mm_q, alm_mm_d;
  logic         alm_pm_q, alm_pm_d;
  bcd8_t        tgt_hh_q, tgt_hh_d;
  bcd8_t        tgt_mm_q, tgt_mm_d;
  logic         tgt_pm_q, tgt_pm_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         match_q;
  logic         ring_q, snoozing_q, set_err_q;
  logic         set_err_d;

  logic         match;
  logic         hit;
  logic         set_legal;
  bcd8_t        snz_hh;
  bcd8_t        snz_mm;
  logic         snz_pm;

  bcd_time_add #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_add (
    .hh_i (bus.hh),
    .mm_i (bus.mm),
    .pm_i (bus.pm),
    .hh_o (snz_hh),
    .mm_o (snz_mm),
    .pm_o (snz_pm)
  );

  // Edge detect so a clock parked on the target second rings only once.
  assign match = (bus.hh == tgt_hh_q) && (bus.mm == tgt_mm_q) &&
                 (bus.pm == tgt_pm_q) && (bus.ss == 8'h00);
  assign hit       = match && !match_q;
  assign set_legal = bcd_time_legal(bus.set_hh, bus.set_mm);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alm_hh_d  = alm_hh_q;
    alm_mm_d  = alm_mm_q;
    alm_pm_d  = alm_pm_q;
    tgt_hh_d  = tgt_hh_q;
    tgt_mm_d  = tgt_mm_q;
    tgt_pm_d  = tgt_pm_q;
    set_err_d = 1'b0;

    if (bus.set_valid) begin
      if (set_legal) begin
        alm_hh_d = bus.set_hh;
        alm_mm_d = bus.set_mm;
        alm_pm_d = bus.set_pm;
      end else begin
        set_err_d = 1'b1;
      end
    end

    unique case (state_q)
      DISARMED: begin
        if (bus.arm_en) state_d = ARMED;
      end
      ARMED: begin
        if (hit) begin
          state_d = RINGING;
          cnt_d   = 8'd0;
        end
      end
      RINGING: begin
        if (bus.stop) begin
          state_d = ARMED;
        end else if (bus.snooze) begin
          state_d  = SNOOZE;
          tgt_hh_d = snz_hh;
          tgt_mm_d = snz_mm;
          tgt_pm_d = snz_pm;
        end else if (bus.ena) begin
          if (cnt_q == 8'(RING_SECS - 1)) state_d = ARMED;
          else                            cnt_d   = cnt_q + 8'd1;
        end
      end
      SNOOZE: begin
        if (bus.stop) begin
          state_d = ARMED;
        end else if (hit) begin
          state_d = RINGING;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = DISARMED;
    endcase

    if (bus.set_valid && set_legal) state_d = ARMED;
    if (!bus.arm_en)                state_d = DISARMED;

    // Outside RINGING/SNOOZE the target tracks the stored alarm, which also
    // covers the reload on every entry into ARMED.
    if ((state_d == ARMED) || (state_d == DISARMED)) begin
      tgt_hh_d = alm_hh_d;
      tgt_mm_d = alm_mm_d;
      tgt_pm_d = alm_pm_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= DISARMED;
      alm_hh_q   <= RESET_HH;
      alm_mm_q   <= RESET_MM;
      alm_pm_q   <= 1'b0;
      tgt_hh_q   <= RESET_HH;
      tgt_mm_q   <= RESET_MM;
      tgt_pm_q   <= 1'b0;
      cnt_q      <= 8'd0;
      match_q    <= 1'b0;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alm_hh_q   <= alm_hh_d;
      alm_mm_q   <= alm_mm_d;
      alm_pm_q   <= alm_pm_d;
      tgt_hh_q   <= tgt_hh_d;
      tgt_mm_q   <= tgt_mm_d;
      tgt_pm_q   <= tgt_pm_d;
      cnt_q      <= cnt_d;
      match_q    <= match;
      ring_q     <= (state_d == RINGING);
      snoozing_q <= (state_d == SNOOZE);
      set_err_q  <= set_err_d;
    end
  end

  assign bus.ring      = ring_q;
  assign bus.snoozing  = snoozing_q;
  assign bus.set_err   = set_err_q;
  assign bus.alm_hh    = alm_hh_q;
  assign bus.alm_mm    = alm_mm_q;
  assign bus.alm_pm    = alm_pm_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: a vector table for set/hit behaviour, then
// hand-written sequences for timeout, snooze, stop, disarm and async reset.
module tb_alarm_unit;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  alarm_unit_if bus ();

  alarm_unit #(
    .RING_SECS  (60),
    .SNOOZE_MIN (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        arm_en;
    logic        set_valid;
    bcd8_t       set_hh;
    bcd8_t       set_mm;
    logic        set_pm;
    logic        stop;
    logic        snooze;
    logic        ena;
    bcd8_t       hh;
    bcd8_t       mm;
    bcd8_t       ss;
    logic        pm;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // {ring, snoozing, set_err, alm_hh, alm_mm, alm_pm}
  function automatic logic [19:0] ex(input logic r, input logic s, input logic e,
                                     input bcd8_t ah, input bcd8_t am, input logic ap);
    return {r, s, e, ah, am, ap};
  endfunction

  function automatic vec_t mk(input string name, input logic sv, input bcd8_t sh,
                              input bcd8_t sm, input logic sp, input logic st,
                              input logic sn, input logic en, input bcd8_t h,
                              input bcd8_t m, input bcd8_t s, input logic p,
                              input logic [19:0] exp);
    vec_t v;
    v.arm_en = 1'b1; v.set_valid = sv; v.set_hh = sh; v.set_mm = sm; v.set_pm = sp;
    v.stop = st; v.snooze = sn; v.ena = en;
    v.hh = h; v.mm = m; v.ss = s; v.pm = p;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input bcd8_t h, input bcd8_t m, input bcd8_t s, input logic p);
    bus.hh = h; bus.mm = m; bus.ss = s; bus.pm = p;
  endtask

  task automatic set_ctl(input logic st, input logic sn, input logic en);
    bus.set_valid = 1'b0; bus.stop = st; bus.snooze = sn; bus.ena = en;
  endtask

  task automatic load(input bcd8_t h, input bcd8_t m, input logic p);
    bus.set_valid = 1'b1; bus.set_hh = h; bus.set_mm = m; bus.set_pm = p;
  endtask

  task automatic check(input string name, input logic [19:0] exp);
    logic [19:0] act;
    act = {bus.ring, bus.snoozing, bus.set_err, bus.alm_hh, bus.alm_mm, bus.alm_pm};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: outputs {ring,snz,err,hh,mm,pm} got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input alarm_state_e exp);
    n_vec++;
    if (bus.dbg_state !== exp) begin
      n_err++;
      $display("FAIL %s: state got %0d, expected %0d", name, bus.dbg_state, exp);
    end
  endtask

  initial begin
    // clock/reset: clock parked on the reset alarm time while arming
    reset_n = 1'b0;
    bus.arm_en = 1'b1;
    bus.set_hh = 8'h00; bus.set_mm = 8'h00; bus.set_pm = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0);
    set_time(8'h12, 8'h00, 8'h00, 1'b0);
    #12;
    check("reset_outputs", ex(0, 0, 0, 8'h12, 8'h00, 0));
    check_state("reset_state", DISARMED);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    check_state("armed_after_reset", ARMED);
    check("arm_on_target_no_ring_1", ex(0, 0, 0, 8'h12, 8'h00, 0));
    tick();
    check("arm_on_target_no_ring_2", ex(0, 0, 0, 8'h12, 8'h00, 0));

    // table-driven vectors
    vecs.push_back(mk("illegal_hh13", 1, 8'h13, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00, 8'h30, 0,
                      ex(0, 0, 1, 8'h12, 8'h00, 0)));
    vecs.push_back(mk("set_err_one_cycle", 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00, 8'h30, 0,
                      ex(0, 0, 0, 8'h12, 8'h00, 0)));
    vecs.push_back(mk("illegal_mm6a", 1, 8'h05, 8'h6A, 0, 0, 0, 0, 8'h01, 8'h00, 8'h31, 0,
                      ex(0, 0, 1, 8'h12, 8'h00, 0)));
    vecs.push_back(mk("illegal_hh00", 1, 8'h00, 8'h10, 1, 0, 0, 0, 8'h01, 8'h00, 8'h32, 0,
                      ex(0, 0, 1, 8'h12, 8'h00, 0)));
    vecs.push_back(mk("illegal_hh0a", 1, 8'h0A, 8'h00, 0, 0, 0, 0, 8'h01, 8'h00, 8'h33, 0,
                      ex(0, 0, 1, 8'h12, 8'h00, 0)));
    vecs.push_back(mk("load_1259pm", 1, 8'h12, 8'h59, 1, 0, 0, 0, 8'h01, 8'h00, 8'h34, 0,
                      ex(0, 0, 0, 8'h12, 8'h59, 1)));
    vecs.push_back(mk("load_0730am", 1, 8'h07, 8'h30, 0, 0, 0, 0, 8'h01, 8'h00, 8'h35, 0,
                      ex(0, 0, 0, 8'h07, 8'h30, 0)));
    vecs.push_back(mk("stop_snooze_in_armed", 0, 8'h00, 8'h00, 0, 1, 1, 1, 8'h07, 8'h29, 8'h58, 0,
                      ex(0, 0, 0, 8'h07, 8'h30, 0)));
    vecs.push_back(mk("pre_0730", 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h07, 8'h29, 8'h59, 0,
                      ex(0, 0, 0, 8'h07, 8'h30, 0)));
    vecs.push_back(mk("hit_0730", 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h07, 8'h30, 8'h00, 0,
                      ex(1, 0, 0, 8'h07, 8'h30, 0)));
    vecs.push_back(mk("ring_held", 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h07, 8'h30, 8'h00, 0,
                      ex(1, 0, 0, 8'h07, 8'h30, 0)));

    foreach (vecs[i]) begin
      bus.arm_en = vecs[i].arm_en;
      bus.set_valid = vecs[i].set_valid;
      bus.set_hh = vecs[i].set_hh; bus.set_mm = vecs[i].set_mm; bus.set_pm = vecs[i].set_pm;
      bus.stop = vecs[i].stop; bus.snooze = vecs[i].snooze; bus.ena = vecs[i].ena;
      set_time(vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].pm);
      tick();
      check(vecs[i].name, vecs[i].exp);
    end

    // ring timeout: entry-cycle ena was not counted, so 59 more keep it ringing
    for (int i = 0; i < 59; i++) begin
      set_ctl(1'b0, 1'b0, 1'b1);
      tick();
      check("ring_before_timeout", ex(1, 0, 0, 8'h07, 8'h30, 0));
    end
    set_ctl(1'b0, 1'b0, 1'b1);
    tick();
    check("ring_timeout", ex(0, 0, 0, 8'h07, 8'h30, 0));
    for (int i = 0; i < 3; i++) begin
      set_ctl(1'b0, 1'b0, (i == 1));
      tick();
      check("no_retrigger", ex(0, 0, 0, 8'h07, 8'h30, 0));
    end

    // snooze across midnight: 11:58 PM + 5 = 12:03 AM
    set_ctl(1'b0, 1'b0, 1'b0);
    load(8'h11, 8'h58, 1'b1);
    set_time(8'h11, 8'h57, 8'h30, 1'b1);
    tick();
    check("load_1158pm", ex(0, 0, 0, 8'h11, 8'h58, 1));
    set_ctl(1'b0, 1'b0, 1'b0);
    set_time(8'h11, 8'h57, 8'h59, 1'b1); tick();
    check("pre_1158", ex(0, 0, 0, 8'h11, 8'h58, 1));
    set_time(8'h11, 8'h58, 8'h00, 1'b1); tick();
    check("ring_1158pm", ex(1, 0, 0, 8'h11, 8'h58, 1));
    set_ctl(1'b0, 1'b1, 1'b0);
    set_time(8'h11, 8'h58, 8'h01, 1'b1); tick();
    check("snooze_entry", ex(0, 1, 0, 8'h11, 8'h58, 1));
    set_time(8'h11, 8'h59, 8'h00, 1'b1); tick();
    check("no_resnooze", ex(0, 1, 0, 8'h11, 8'h58, 1));
    set_ctl(1'b0, 1'b0, 1'b0);
    set_time(8'h12, 8'h02, 8'h59, 1'b0); tick();
    check("snooze_wait", ex(0, 1, 0, 8'h11, 8'h58, 1));
    set_time(8'h12, 8'h03, 8'h00, 1'b0); tick();
    check("snooze_ring_1203am", ex(1, 0, 0, 8'h11, 8'h58, 1));
    set_ctl(1'b1, 1'b1, 1'b0); tick();
    check("stop_and_snooze", ex(0, 0, 0, 8'h11, 8'h58, 1));
    check_state("stop_beats_snooze", ARMED);

    // snooze hour wrap: 12:57 AM + 5 = 01:02 AM, then disarm mid-ring
    set_ctl(1'b0, 1'b0, 1'b0);
    load(8'h12, 8'h57, 1'b0);
    set_time(8'h12, 8'h03, 8'h05, 1'b0);
    tick();
    check("load_1257am", ex(0, 0, 0, 8'h12, 8'h57, 0));
    set_ctl(1'b0, 1'b0, 1'b0);
    set_time(8'h12, 8'h56, 8'h59, 1'b0); tick();
    check("pre_1257", ex(0, 0, 0, 8'h12, 8'h57, 0));
    set_time(8'h12, 8'h57, 8'h00, 1'b0); tick();
    check("ring_1257am", ex(1, 0, 0, 8'h12, 8'h57, 0));
    set_ctl(1'b0, 1'b1, 1'b0);
    set_time(8'h12, 8'h57, 8'h01, 1'b0); tick();
    check("snooze_1257", ex(0, 1, 0, 8'h12, 8'h57, 0));
    set_ctl(1'b0, 1'b0, 1'b0);
    set_time(8'h01, 8'h01, 8'h59, 1'b0); tick();
    check("snooze_wait_0102", ex(0, 1, 0, 8'h12, 8'h57, 0));
    set_time(8'h01, 8'h02, 8'h00, 1'b0); tick();
    check("snooze_ring_0102am", ex(1, 0, 0, 8'h12, 8'h57, 0));
    bus.arm_en = 1'b0;
    set_time(8'h01, 8'h02, 8'h01, 1'b0); tick();
    check("disarm_mid_ring", ex(0, 0, 0, 8'h12, 8'h57, 0));
    check_state("disarmed", DISARMED);

    // async reset mid-snooze
    bus.arm_en = 1'b1;
    set_time(8'h12, 8'h56, 8'h59, 1'b0); tick();
    check_state("rearmed", ARMED);
    set_time(8'h12, 8'h57, 8'h00, 1'b0); tick();
    check("ring_again", ex(1, 0, 0, 8'h12, 8'h57, 0));
    set_ctl(1'b0, 1'b1, 1'b0);
    set_time(8'h12, 8'h57, 8'h01, 1'b0); tick();
    check("snooze_before_reset", ex(0, 1, 0, 8'h12, 8'h57, 0));
    set_ctl(1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_snooze", ex(0, 0, 0, 8'h12, 8'h00, 0));
    check_state("async_reset_state", DISARMED);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
